// File: rtl/cpu_keys_in_if.sv
// cpu_keys_in_if
// Avalon-MM slave bus bundle for the key/switch input port.
//   address    : word address of the register (0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAP)
//   chipselect : slave select
//   write_n    : active-low write strobe, qualified by chipselect
//   writedata  : write data, only the low WIDTH bits are meaningful to the slave
//   readdata   : combinational read data, zero wait states
// master modport: the CPU side; slave modport: the input port.
interface cpu_keys_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/cpu_keys_in.sv
// cpu_keys_in
// Nios bus input port: synchronizes and debounces WIDTH raw inputs, captures
// selected edges of the debounced level into sticky EDGECAP bits and raises a
// level interrupt while any captured edge is unmasked.
// Ports:
//   clk     : system clock, single domain
//   reset_n : asynchronous active-low reset
//   bus     : Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   in_port : raw asynchronous inputs
//   irq     : active-high level interrupt = |(EDGECAP & IRQMASK)
// Parameters:
//   WIDTH           : number of input bits (1..32)
//   DEBOUNCE_CYCLES : cycles a synchronized bit must hold before acceptance
//   EDGE_TYPE       : 0 rising, 1 falling, 2 any
//   STABLE_RESET    : reset value of both synchronizer stages and the debounced level
module cpu_keys_in #(
    parameter int unsigned     WIDTH           = 8,
    parameter int unsigned     DEBOUNCE_CYCLES = 50000,
    parameter int unsigned     EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] STABLE_RESET   = {WIDTH{1'b0}}
) (
    input  logic               clk,
    input  logic               reset_n,
    cpu_keys_in_if.slave       bus,
    input  logic [WIDTH-1:0]   in_port,
    output logic               irq
);

    // Counter only has to reach DEBOUNCE_CYCLES-1, so ceil(log2) bits suffice.
    localparam int unsigned CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] stable_r;
    logic [WIDTH-1:0] irqmask_r;
    logic [WIDTH-1:0] edgecap_r;
    logic [CNT_W-1:0] cnt_r     [WIDTH];

    logic [CNT_W-1:0] cnt_nxt_s [WIDTH];
    logic [WIDTH-1:0] stable_nxt_s;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] edgecap_nxt_s;
    logic             wr_en_s;
    logic [31:0]      readdata_s;
    logic             unused_wdata_s;

    // Select which transitions of the debounced level count as an edge event.
    function automatic logic [WIDTH-1:0] edge_events(
        input logic [WIDTH-1:0] old_v,
        input logic [WIDTH-1:0] new_v
    );
        logic [WIDTH-1:0] ev;
        case (EDGE_TYPE)
            32'd0:   ev = new_v & ~old_v;
            32'd1:   ev = old_v & ~new_v;
            default: ev = old_v ^ new_v;
        endcase
        return ev;
    endfunction

    // Upper writedata bits are architecturally ignored.
    assign unused_wdata_s = ^bus.writedata;

    assign wr_en_s = bus.chipselect & ~bus.write_n;

    // Per-bit debounce: any disagreement restarts from 0, acceptance after a full hold.
    always_comb begin
        stable_nxt_s = stable_r;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (sync2_r[i] == stable_r[i]) begin
                cnt_nxt_s[i] = CNT_ZERO;
            end else if (cnt_r[i] == CNT_MAX) begin
                stable_nxt_s[i] = sync2_r[i];
                cnt_nxt_s[i]    = CNT_ZERO;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Edge capture: write-1-to-clear, but a same-cycle edge event keeps the bit set.
    always_comb begin
        edge_s = edge_events(stable_r, stable_nxt_s);
        if (wr_en_s && (bus.address == 2'd3)) begin
            clr_s = bus.writedata[WIDTH-1:0];
        end else begin
            clr_s = {WIDTH{1'b0}};
        end
        edgecap_nxt_s = (edgecap_r & ~clr_s) | edge_s;
    end

    // Synchronizer, debounce state, mask and capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r   <= STABLE_RESET;
            sync2_r   <= STABLE_RESET;
            stable_r  <= STABLE_RESET;
            irqmask_r <= {WIDTH{1'b0}};
            edgecap_r <= {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            sync1_r   <= in_port;
            sync2_r   <= sync1_r;
            stable_r  <= stable_nxt_s;
            edgecap_r <= edgecap_nxt_s;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            if (wr_en_s && (bus.address == 2'd2)) begin
                irqmask_r <= bus.writedata[WIDTH-1:0];
            end else begin
                irqmask_r <= irqmask_r;
            end
        end
    end

    // Zero-wait-state read mux, zero-extended above WIDTH; not gated by chipselect.
    always_comb begin
        readdata_s = 32'h0000_0000;
        case (bus.address)
            2'd0:    readdata_s[WIDTH-1:0] = stable_r;
            2'd1:    readdata_s = 32'h0000_0000;
            2'd2:    readdata_s[WIDTH-1:0] = irqmask_r;
            2'd3:    readdata_s[WIDTH-1:0] = edgecap_r;
            default: readdata_s = 32'h0000_0000;
        endcase
    end

    assign bus.readdata = readdata_s;

    // Interrupt depends only on registers, so raw inputs cannot glitch it.
    assign irq = |(edgecap_r & irqmask_r);

endmodule

// File: tb/tb_cpu_keys_in.sv
module tb_cpu_keys_in;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port0;
    logic [7:0]  in_port1;
    logic [7:0]  in_port2;
    logic        irq0;
    logic        irq1;
    logic        irq2;

    int total;
    int bad;

    cpu_keys_in_if bus0();
    cpu_keys_in_if bus1();
    cpu_keys_in_if bus2();

    assign bus0.address = address;  assign bus0.chipselect = chipselect;
    assign bus0.write_n = write_n;  assign bus0.writedata  = writedata;
    assign bus1.address = address;  assign bus1.chipselect = chipselect;
    assign bus1.write_n = write_n;  assign bus1.writedata  = writedata;
    assign bus2.address = address;  assign bus2.chipselect = chipselect;
    assign bus2.write_n = write_n;  assign bus2.writedata  = writedata;

    cpu_keys_in #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .STABLE_RESET(8'h00)) u_rise (
        .clk(clk), .reset_n(reset_n), .bus(bus0.slave), .in_port(in_port0), .irq(irq0));
    cpu_keys_in #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .STABLE_RESET(8'h00)) u_fall (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave), .in_port(in_port1), .irq(irq1));
    cpu_keys_in #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .STABLE_RESET(8'h00)) u_any (
        .clk(clk), .reset_n(reset_n), .bus(bus2.slave), .in_port(in_port2), .irq(irq2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } bus_vec_t;

    bus_vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input int d, input logic [1:0] a, output logic [31:0] v);
        address = a;
        #1;
        case (d)
            0:       v = bus0.readdata;
            1:       v = bus1.readdata;
            default: v = bus2.readdata;
        endcase
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        total = 0;
        bad   = 0;

        vecs[0] = '{1'b1, 2'd0, 32'h0000_00FF, 32'h0000_00A5, 1'b0};
        vecs[1] = '{1'b1, 2'd1, 32'h0000_00FF, 32'h0000_0000, 1'b0};
        vecs[2] = '{1'b1, 2'd2, 32'hFFFF_FF3C, 32'h0000_003C, 1'b1};
        vecs[3] = '{1'b0, 2'd3, 32'h0000_0000, 32'h0000_00A5, 1'b1};
        vecs[4] = '{1'b1, 2'd3, 32'h0000_0024, 32'h0000_0081, 1'b0};
        vecs[5] = '{1'b1, 2'd2, 32'h0000_0001, 32'h0000_0001, 1'b1};
        vecs[6] = '{1'b1, 2'd2, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[7] = '{1'b1, 2'd3, 32'h0000_00FF, 32'h0000_0000, 1'b0};
        vecs[8] = '{1'b0, 2'd0, 32'h0000_0000, 32'h0000_00A5, 1'b0};

        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port0   = 8'hA5;
        in_port1   = 8'h00;
        in_port2   = 8'h00;
        reset_n    = 1'b0;

        // Reset state
        ticks(2);
        for (int a = 0; a < 4; a++) begin
            rd(0, 2'(a), v);
            chk($sformatf("reset_rd_a%0d", a), v, 32'h0);
        end
        chk("reset_irq", {31'h0, irq0}, 32'h0);
        reset_n = 1'b1;
        ticks(5);
        rd(0, 2'd0, v); chk("release_data_e4", v, 32'h00);
        tick();
        rd(0, 2'd0, v); chk("release_data_e5", v, 32'hA5);
        rd(0, 2'd3, v); chk("release_edgecap", v, 32'hA5);
        chk("release_irq", {31'h0, irq0}, 32'h0);

        // Bus register map vectors
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
            rd(0, vecs[i].addr, v);
            chk($sformatf("bus_vec%0d_rd", i), v, vecs[i].exp_rd);
            chk($sformatf("bus_vec%0d_irq", i), {31'h0, irq0}, {31'h0, vecs[i].exp_irq});
            tick();
        end

        // Fresh start for debounce
        in_port0 = 8'h00;
        reset_n  = 1'b0;
        ticks(2);
        reset_n  = 1'b1;
        ticks(2);

        // 3-cycle pulse must be filtered
        in_port0 = 8'h01;
        ticks(3);
        in_port0 = 8'h00;
        for (int k = 0; k < 8; k++) begin
            tick();
            rd(0, 2'd0, v); chk($sformatf("glitch_data_t%0d", k), v, 32'h00);
            rd(0, 2'd3, v); chk($sformatf("glitch_cap_t%0d", k), v, 32'h00);
        end

        // Held input with interrupt enabled
        wr(2'd2, 32'h01);
        in_port0 = 8'h01;
        ticks(5);
        rd(0, 2'd0, v); chk("hold_data_e4", v, 32'h00);
        chk("hold_irq_e4", {31'h0, irq0}, 32'h0);
        tick();
        rd(0, 2'd0, v); chk("hold_data_e5", v, 32'h01);
        rd(0, 2'd3, v); chk("hold_cap_e5", v, 32'h01);
        chk("hold_irq_e5", {31'h0, irq0}, 32'h1);
        wr(2'd3, 32'h01);
        chk("clear_irq", {31'h0, irq0}, 32'h0);
        rd(0, 2'd3, v); chk("clear_cap", v, 32'h00);
        in_port0 = 8'h03;
        ticks(6);
        rd(0, 2'd3, v); chk("unmasked_cap", v, 32'h02);
        chk("unmasked_irq", {31'h0, irq0}, 32'h0);
        rd(0, 2'd0, v); chk("unmasked_data", v, 32'h03);

        // Edge types: falling-only and any-edge instances
        in_port1 = 8'h08;
        in_port2 = 8'h08;
        ticks(6);
        rd(1, 2'd0, v); chk("fall_rise_data", v, 32'h08);
        rd(1, 2'd3, v); chk("fall_rise_cap", v, 32'h00);
        rd(2, 2'd3, v); chk("any_rise_cap", v, 32'h08);
        wr(2'd3, 32'h08);
        rd(2, 2'd3, v); chk("any_clear_cap", v, 32'h00);
        rd(0, 2'd3, v); chk("rise_keep_cap", v, 32'h02);
        in_port1 = 8'h00;
        in_port2 = 8'h00;
        ticks(6);
        rd(1, 2'd0, v); chk("fall_fall_data", v, 32'h00);
        rd(1, 2'd3, v); chk("fall_fall_cap", v, 32'h08);
        chk("fall_irq_masked", {31'h0, irq1}, 32'h0);
        rd(2, 2'd3, v); chk("any_fall_cap", v, 32'h08);

        // Collision: clear and edge event on the same edge
        wr(2'd3, 32'h08);
        rd(2, 2'd3, v); chk("coll_pre_clear", v, 32'h00);
        in_port2 = 8'h08;
        ticks(5);
        rd(2, 2'd3, v); chk("coll_cap_e4", v, 32'h00);
        wr(2'd3, 32'h08);
        rd(2, 2'd3, v); chk("coll_cap_e5", v, 32'h08);

        // Reset with bit 2 mid-debounce (counter at 2)
        in_port0 = 8'h07;
        ticks(4);
        reset_n = 1'b0;
        ticks(2);
        reset_n = 1'b1;
        ticks(5);
        rd(0, 2'd0, v); chk("mid_rst_data_e4", v, 32'h00);
        rd(0, 2'd3, v); chk("mid_rst_cap_e4", v, 32'h00);
        tick();
        rd(0, 2'd0, v); chk("mid_rst_data_e5", v, 32'h07);
        rd(0, 2'd3, v); chk("mid_rst_cap_e5", v, 32'h07);
        rd(0, 2'd2, v); chk("mid_rst_mask", v, 32'h00);
        chk("mid_rst_irq", {31'h0, irq0}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_keys_in.md
# cpu_keys_in

Avalon-MM slave input port on the Nios CPU bus: the read-side counterpart of the LED output PIO. It samples the push-button/switch inputs and debounces them per bit, then captures selected edges. When an unmasked captured edge is pending it raises an interrupt to the CPU. Software reads the debounced level, programs an interrupt mask and clears captured edges by writing 1s.

## Interface
- WIDTH, 8: number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000: cycles a synchronized bit must hold a new value before it is accepted (≥1; 1 ms at 50 MHz).
- EDGE_TYPE, 0: captured edge on the debounced level: 0 rising, 1 falling, 2 any.
- STABLE_RESET, 0: WIDTH-bit reset value of the debounced level and both synchronizer stages.
- clk  in  1  system clock; every register is in this single clock domain.
- reset_n  in  1  reset. It is asynchronous and active-low.
- address  in  2  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; only bits [WIDTH-1:0] are used.
- in_port  in  WIDTH  raw asynchronous inputs.
- readdata  out  32  read data: combinational, zero wait states, zero-extended above WIDTH.
- irq  out  1  level interrupt, active-high.

## Operation
- Register map:
  - 0 DATA: read returns the debounced level; writes are ignored.
  - 1 reserved: reads 0; writes are ignored.
  - 2 IRQMASK: read/write, bits [WIDTH-1:0].
  - 3 EDGECAP: read returns the capture bits; a write clears each bit where writedata is 1 (write-1-to-clear).
- Reads have no side effects. readdata is valid whenever address is driven, and it is not gated by chipselect.
- Synchronizer: 2-flop per bit, sync1 <= in_port, then sync2 <= sync1.
- Debounce uses one counter per bit, with width ceil(log2(DEBOUNCE_CYCLES)), minimum 1. For each bit:
  - If sync2 == stable, the counter clears.
  - Otherwise, if the counter == DEBOUNCE_CYCLES-1, stable <= sync2 and the counter clears.
  - Otherwise the counter increments.
  - A glitch shorter than DEBOUNCE_CYCLES in sync2 never reaches stable, and it restarts the count from 0.
- Edge event: a bit whose stable value changes at this edge, matching EDGE_TYPE (rising 0->1, falling 1->0, any).
- EDGECAP[i] is set by an edge event and cleared only by a write-1 or by reset. It is sticky across multiple events.
- If an edge event and a write-1-clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- irq = |(EDGECAP & IRQMASK), computed combinationally from registers; there is no glitch path from in_port.
- Reset values:
  - sync1, sync2 and stable = STABLE_RESET.
  - Counters, IRQMASK and EDGECAP = 0, so irq = 0 and readdata at address 0 = STABLE_RESET.
- Reset mid-debounce discards the pending count. No edge is captured for the lost transition; it re-debounces after release if the input still differs from STABLE_RESET.

## Timing
- Let in_port change (held) before clock edge E0:
  - sync1 updates at E0 and sync2 at E1.
  - stable and EDGECAP update at E(1+DEBOUNCE_CYCLES).
  - irq asserts after that same edge when the bit is masked in.
- With DEBOUNCE_CYCLES=1, input to DATA latency is 2 edges.
- Writes take effect at the clock edge where chipselect=1 and write_n=0; the new value is visible on readdata and irq immediately after that edge.
- Clearing the last pending masked bit deasserts irq after the write edge. Clearing IRQMASK has the same effect.
- Counter arithmetic is unsigned and never wraps; it is bounded by the clear at DEBOUNCE_CYCLES-1.

## Test plan
- **Reset:** assert reset_n=0 with in_port=8'hA5, STABLE_RESET=0 → readdata=0 at addresses 0/1/2/3 and irq=0. Release: after 2+4 edges (DEBOUNCE_CYCLES=4), DATA reads 8'hA5 and EDGECAP reads 8'hA5 (rising).
- **Debounce:** pulse in_port[0] high for 3 cycles with DEBOUNCE_CYCLES=4 → DATA bit 0 never changes and EDGECAP stays 0. Hold it 4+ cycles → DATA[0]=1 exactly at edge E5.
- **Interrupt:** write IRQMASK=8'h01, then raise bit 0 → irq=1 after E5.
  - Write EDGECAP=8'h01 → irq=0 the next cycle.
  - Raise bit 1 with mask bit 1 clear → EDGECAP=8'h02 and irq stays 0.
- **Edge types and collision:** EDGE_TYPE=1 with a falling bit 3 → EDGECAP=8'h08. EDGE_TYPE=2 → both directions capture. Issue a write-1-clear on bit 3 in the cycle stable[3] changes → EDGECAP[3] remains 1.
- **Bus:** write 8'hFF to address 0 and to address 1 → DATA is unchanged and address 1 reads 0. Write IRQMASK=32'hFFFF_FF3C → reads back 32'h0000_003C.
- **Mid-debounce reset:** assert reset while bit 2's counter is at 2 → after release there is no capture until the input is again held ≥4 cycles, and the capture occurs at the expected edge.
